clk_en_gen: RTL and testbench
=============================

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32, divisor/counter width in bits.
REQ-003 Parameter RST_DIV, default 450, divisor loaded into every channel at reset (>=2).
REQ-004 Parameter RST_EN, default all ones (NUM_CH bits), per-channel enable value at reset.
REQ-005 Ports: clk input 1 system clock; rst input 1 reset. One clock; reset is synchronous and active-high.
REQ-006 cfg_we  input  1  configuration write strobe, one cycle.
REQ-007 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-008 cfg_div  input  CNT_W  new divisor for target channel.
REQ-009 cfg_en  input  1  new enable for target channel.
REQ-010 sync  input  1  restart all enabled channels in phase.
REQ-011 tick  output  NUM_CH  per-channel single-cycle strobe, one per period.
REQ-012 clk_out  output  NUM_CH  per-channel square wave, flop-driven, glitch-free.
REQ-013 cfg_err  output  1  one-cycle pulse on rejected write.

Function
REQ-014 Each channel holds active divisor div, shadow divisor sdiv, enable en, counter cnt (CNT_W bits).
REQ-015 Enabled channel: cnt counts 0..div-1 and wraps to 0; at wrap, div <= sdiv.
REQ-016 tick[i] in cycle t+1 = en[i] AND cnt[i](t)==div[i]-1; exactly one high cycle per div cycles.
REQ-017 clk_out[i] in cycle t+1 = en[i] AND cnt[i](t) < ceil(div[i]/2); odd div: high ceil(div/2), low floor(div/2).
REQ-018 Disabled channel: cnt held 0, tick and clk_out 0 from the next cycle.
REQ-019 Write accepted when cfg_we=1, cfg_ch<NUM_CH, cfg_div>=2: sdiv<=cfg_div, en<=cfg_en.
REQ-020 Accepted write to running channel (en stays 1): new divisor takes effect at the next wrap; the current period completes unchanged.
REQ-021 Accepted write to a disabled channel, or one enabling it: div and sdiv both load cfg_div immediately, cnt<=0.
REQ-022 Rejected write (cfg_ch>=NUM_CH or cfg_div<2): no state change; cfg_err=1 in next cycle only.
REQ-023 cfg_err registered; a rejected write every cycle gives cfg_err high every cycle.
REQ-024 sync=1: every enabled channel cnt<=0 and div<=sdiv; sync overrides wrap in the same cycle.
REQ-025 sync and accepted cfg_we in the same cycle: write applied first, so the target channel restarts with cfg_div active.
REQ-026 Divisor 2^CNT_W-1 supported without overflow; counter compare is unsigned.

Reset
REQ-027 While rst=1: cnt=0, div=sdiv=RST_DIV, en=RST_EN, tick=0, clk_out=0, cfg_err=0; cfg_we and sync ignored.
REQ-028 First cycle after release cnt=0; with RST_DIV=4, first tick occurs in the 5th cycle after release.
REQ-029 rst mid-period discards pending shadow divisors; no residual tick.

Structure
REQ-030 Shared package clk_en_pkg holds default CNT_W, MIN_DIV=2 constant, and the channel config struct (div, sdiv, en).
REQ-031 One sub-module clk_en_chan implements a single channel (counter, shadow, outputs) and is instantiated NUM_CH times via generate; top holds decode, error flag, sync fan-out.

Verification
REQ-032 Reset release with defaults NUM_CH=4, RST_DIV=4 -> all tick pulse in cycles 5,9,13; clk_out high 2, low 2.
REQ-033 Write ch1 div=5 mid-period -> ch1 finishes its 4-cycle period, then ticks every 5; clk_out high 3/low 2; other channels unaffected.
REQ-034 Write cfg_ch=2, cfg_div=1 -> cfg_err one cycle, ch2 keeps div=4; cfg_ch=5 with NUM_CH=4 -> cfg_err, no change.
REQ-035 Disable ch0, then re-enable with div=3 -> outputs 0 while disabled; ticks every 3 starting 3 cycles after re-enable.
REQ-036 Channels at div 3 and 7 out of phase, assert sync -> both tick together 3 and 7 cycles later; sync with write div=6 on ch2 -> ch2 restarts at 6.
REQ-037 CNT_W=8, div=255 -> tick every 255 cycles, no wrap error; rst asserted mid-period -> outputs 0 next cycle, restart from RST_DIV.

Source files
------------

// File: rtl/clk_en_pkg.sv
// Shared constants and per-channel configuration record for the clock-enable generator.
package clk_en_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int MIN_DIV   = 2;

    // Divisor fields are held at DEF_CNT_W; narrower counters zero-extend into them,
    // so CNT_W must not exceed DEF_CNT_W.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] div;
        logic [DEF_CNT_W-1:0] sdiv;
        logic                 en;
    } chan_cfg_t;

endpackage

// File: rtl/clk_en_chan.sv
// One divider channel: wrap counter with shadowed divisor, registered tick and square-wave outputs.
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int   CNT_W   = DEF_CNT_W,
    parameter int   RST_DIV = 450,
    parameter logic RST_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_en,
    input  logic             sync,
    output logic             tick,
    output logic             clk_out
);

    localparam logic [DEF_CNT_W-1:0] RST_DIV_W = DEF_CNT_W'(RST_DIV);
    localparam logic [DEF_CNT_W-1:0] ONE       = DEF_CNT_W'(1);

    chan_cfg_t            cfg_q, cfg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DEF_CNT_W-1:0] cnt_w, wr_div_w, half;
    logic                 at_end;

    assign wr_div_w = DEF_CNT_W'(wr_div);
    assign cnt_w    = DEF_CNT_W'(cnt_q);
    assign at_end   = (cnt_w == cfg_q.div - ONE);
    // ceil(div/2) without the div+1 overflow at the top of the range
    assign half     = (cfg_q.div >> 1) + DEF_CNT_W'(cfg_q.div[0]);

    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        if (wr) begin
            cfg_d.sdiv = wr_div_w;
            cfg_d.en   = wr_en;
            if (!cfg_q.en) begin
                cfg_d.div = wr_div_w;
            end
        end
        if (!cfg_d.en || !cfg_q.en) begin
            cnt_d = '0;
        end else if (sync || at_end) begin
            cnt_d     = '0;
            cfg_d.div = cfg_d.sdiv;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= '{div: RST_DIV_W, sdiv: RST_DIV_W, en: RST_EN};
            cnt_q   <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            tick    <= cfg_q.en && at_end;
            clk_out <= cfg_q.en && (cnt_w < half);
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: write decode, reject flag and sync fan-out
// around NUM_CH independent divider channels.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                NUM_CH  = 4,
    parameter int                CNT_W   = DEF_CNT_W,
    parameter int                RST_DIV = 450,
    parameter logic [NUM_CH-1:0] RST_EN  = '1,
    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic              cfg_err
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic ch_ok, div_ok, accept;

    assign ch_ok  = ({1'b0, cfg_ch} < NUM_CH_L);
    assign div_ok = (cfg_div >= CNT_W'(MIN_DIV));
    assign accept = cfg_we && ch_ok && div_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !accept;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_chan #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV),
            .RST_EN  (RST_EN[i])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr      (accept && (cfg_ch == CH_W'(i))),
            .wr_div  (cfg_div),
            .wr_en   (cfg_en),
            .sync    (sync),
            .tick    (tick[i]),
            .clk_out (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: a 4-channel 32-bit instance and a 3-channel 8-bit instance.
module tb_clk_en_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst8 = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_div = '0;
    logic        cfg_en = 1'b0;
    logic        sync = 1'b0;
    logic [3:0]  tick, clk_out;
    logic        cfg_err;
    logic [2:0]  tick8, clk_out8;
    logic        cfg_err8;

    typedef struct {
        int         cyc;
        logic [8:0] v;
    } exp_t;

    exp_t ev_q[$];
    exp_t co_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    clk_en_gen #(.NUM_CH(4), .CNT_W(32), .RST_DIV(4)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .sync(sync), .tick(tick), .clk_out(clk_out), .cfg_err(cfg_err)
    );

    clk_en_gen #(.NUM_CH(3), .CNT_W(8), .RST_DIV(255)) dut8 (
        .clk(clk), .rst(rst8), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div[7:0]),
        .cfg_en(cfg_en), .sync(sync), .tick(tick8), .clk_out(clk_out8), .cfg_err(cfg_err8)
    );

    // Event vector layout: {cfg_err8, tick8, cfg_err, tick}; level vector: {2'b0, clk_out8, clk_out}
    function automatic void ev_m(input int c, input logic e, input logic [3:0] t);
        exp_t x;
        x.cyc = c;
        x.v   = {4'b0000, e, t};
        ev_q.push_back(x);
    endfunction

    function automatic void ev_8(input int c, input logic e, input logic [2:0] t);
        exp_t x;
        x.cyc = c;
        x.v   = {e, t, 5'b00000};
        ev_q.push_back(x);
    endfunction

    function automatic void co_m(input int c, input logic [3:0] v);
        exp_t x;
        x.cyc = c;
        x.v   = {5'b00000, v};
        co_q.push_back(x);
    endfunction

    function automatic void co_8(input int c, input logic [2:0] v);
        exp_t x;
        x.cyc = c;
        x.v   = {2'b00, v, 4'b0000};
        co_q.push_back(x);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [31:0] d, input logic en);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = d;
        cfg_en  = en;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    task automatic do_reset(input bit which8, output int rel);
        if (which8) rst8 = 1'b1; else rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (which8) rst8 = 1'b0; else rst = 1'b0;
        rel = cyc;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        exp_t       x;
        logic [8:0] act_ev, act_co;
        forever begin
            @(posedge clk);
            #2;
            act_ev = {cfg_err8, tick8, cfg_err, tick};
            act_co = {2'b00, clk_out8, clk_out};
            if (act_ev != 9'd0) begin
                total++;
                if (ev_q.size() == 0) begin
                    bad++;
                    $display("FAIL event cyc=%0d got=%b expected none", cyc, act_ev);
                end else begin
                    x = ev_q.pop_front();
                    if (x.cyc != cyc || x.v != act_ev) begin
                        bad++;
                        $display("FAIL event cyc=%0d got=%b expected cyc=%0d val=%b", cyc, act_ev, x.cyc, x.v);
                    end
                end
            end
            while (co_q.size() > 0 && co_q[0].cyc <= cyc) begin
                x = co_q.pop_front();
                total++;
                if (x.cyc != cyc || x.v != act_co) begin
                    bad++;
                    $display("FAIL clk_out cyc=%0d got=%b expected cyc=%0d val=%b", cyc, act_co, x.cyc, x.v);
                end
            end
            if (done) begin
                while (ev_q.size() > 0) begin
                    x = ev_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_event expected cyc=%0d val=%b got none", x.cyc, x.v);
                end
                while (co_q.size() > 0) begin
                    x = co_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_clk_out expected cyc=%0d val=%b got none", x.cyc, x.v);
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        int r, q, q2;
        @(negedge clk);

        // reset release at div 4, then ch1 retargeted to 5 mid-period
        do_reset(1'b0, r);
        ev_m(r+4, 0, 4'hF);  ev_m(r+8, 0, 4'hF);  ev_m(r+12, 0, 4'hF); ev_m(r+16, 0, 4'hF);
        ev_m(r+20, 0, 4'hD); ev_m(r+21, 0, 4'h2); ev_m(r+24, 0, 4'hD); ev_m(r+26, 0, 4'h2);
        ev_m(r+28, 0, 4'hD); ev_m(r+31, 0, 4'h2); ev_m(r+32, 0, 4'hD);
        co_m(r+1, 4'hF);  co_m(r+2, 4'hF);  co_m(r+3, 4'h0);  co_m(r+4, 4'h0);  co_m(r+5, 4'hF);
        co_m(r+17, 4'hF); co_m(r+18, 4'hF); co_m(r+19, 4'h2); co_m(r+20, 4'h0); co_m(r+21, 4'hD);
        co_m(r+22, 4'hF); co_m(r+23, 4'h2); co_m(r+24, 4'h2); co_m(r+25, 4'hD); co_m(r+26, 4'hD);
        co_m(r+34, 4'h0);
        wait_until(r+13); wr(2'd1, 32'd5, 1'b1);
        wait_until(r+33); do_reset(1'b0, r);

        // rejected writes, then disable/re-enable ch0 at div 3
        ev_m(r+2, 1, 4'h0);  ev_m(r+4, 0, 4'hF);  ev_m(r+6, 1, 4'h0);  ev_m(r+7, 1, 4'h0);
        ev_m(r+8, 1, 4'hF);  ev_m(r+12, 0, 4'hF); ev_m(r+16, 0, 4'hF); ev_m(r+20, 0, 4'hE);
        ev_m(r+24, 0, 4'hE); ev_m(r+28, 0, 4'hE); ev_m(r+32, 0, 4'hE); ev_m(r+33, 0, 4'h1);
        ev_m(r+36, 0, 4'hF); ev_m(r+39, 0, 4'h1); ev_m(r+40, 0, 4'hE);
        co_m(r+18, 4'hF); co_m(r+19, 4'h0); co_m(r+20, 4'h0); co_m(r+21, 4'hE); co_m(r+22, 4'hE);
        co_m(r+30, 4'hE); co_m(r+31, 4'h1); co_m(r+32, 4'h1); co_m(r+33, 4'hE); co_m(r+34, 4'hF);
        co_m(r+35, 4'h1); co_m(r+36, 4'h0); co_m(r+42, 4'h0);
        wait_until(r+1);  wr(2'd2, 32'd1, 1'b1);
        wait_until(r+5);  wr(2'd0, 32'd1, 1'b0); wr(2'd3, 32'd0, 1'b0); wr(2'd2, 32'd1, 1'b1);
        wait_until(r+17); wr(2'd0, 32'd4, 1'b0);
        wait_until(r+29); wr(2'd0, 32'd3, 1'b1);
        wait_until(r+41); do_reset(1'b0, r);

        // ch0 div 3, ch1 div 7, then sync together with ch2 <- 6
        ev_m(r+4, 0, 4'hF);  ev_m(r+7, 0, 4'h1);  ev_m(r+8, 0, 4'hC);  ev_m(r+10, 0, 4'h1);
        ev_m(r+11, 0, 4'h2); ev_m(r+12, 0, 4'hC); ev_m(r+13, 0, 4'h1); ev_m(r+17, 0, 4'h1);
        ev_m(r+18, 0, 4'h8); ev_m(r+20, 0, 4'h5); ev_m(r+21, 0, 4'h2); ev_m(r+22, 0, 4'h8);
        ev_m(r+23, 0, 4'h1); ev_m(r+26, 0, 4'hD); ev_m(r+28, 0, 4'h2);
        co_m(r+15, 4'hF); co_m(r+17, 4'h6); co_m(r+18, 4'h3); co_m(r+29, 4'h0);
        wait_until(r+1);  wr(2'd0, 32'd3, 1'b1); wr(2'd1, 32'd7, 1'b1);
        wait_until(r+13); sync = 1'b1; wr(2'd2, 32'd6, 1'b1); sync = 1'b0;
        wait_until(r+28); rst = 1'b1;

        // 8-bit instance at div 255: out-of-range channel, mid-period reset
        do_reset(1'b1, q);
        ev_8(q+11, 1, 3'h0); ev_8(q+255, 0, 3'h7); ev_8(q+510, 0, 3'h7);
        co_8(q+128, 3'h7); co_8(q+129, 3'h0); co_8(q+255, 3'h0); co_8(q+256, 3'h7); co_8(q+601, 3'h0);
        wait_until(q+10);  wr(2'd3, 32'd5, 1'b1);
        wait_until(q+600); do_reset(1'b1, q2);
        ev_8(q2+255, 0, 3'h7);
        co_8(q2+1, 3'h7);
        wait_until(q2+260);
        done = 1'b1;
    end

endmodule
